// File: rtl/rvx_board_input_conditioner_if.sv
// Signal bundle between the board pins, the input conditioner and the SoC.
// The master side is the conditioner; the slave side drives the pins and consumes the results.
interface rvx_board_input_conditioner_if #(
    parameter int NUM_INPUTS = 4
);
    logic [NUM_INPUTS-1:0] raw_inputs;
    logic [NUM_INPUTS-1:0] debounced;
    logic [NUM_INPUTS-1:0] rise_pulse;
    logic [NUM_INPUTS-1:0] fall_pulse;
    logic                  soc_reset_n;
    logic                  clock_enable;

    modport master (
        input  raw_inputs,
        output debounced,
        output rise_pulse,
        output fall_pulse,
        output soc_reset_n,
        output clock_enable
    );

    modport slave (
        output raw_inputs,
        input  debounced,
        input  rise_pulse,
        input  fall_pulse,
        input  soc_reset_n,
        input  clock_enable
    );
endinterface

// File: rtl/rvx_board_input_conditioner.sv
// Board input conditioning: per-channel synchroniser + counter debouncer with edge pulses,
// a stretched SoC reset driven by one debounced button, and a clock-enable strobe.
module rvx_board_input_conditioner #(
    parameter int NUM_INPUTS        = 4,
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int RESET_INPUT_INDEX = 0,
    parameter int RESET_HOLD_CYCLES = 1024,
    parameter int CLOCK_DIVIDER     = 2
) (
    input  logic                          clock,
    input  logic                          reset_n,
    rvx_board_input_conditioner_if.master io
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
    localparam int DIV_W  = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD_CYCLES);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLOCK_DIVIDER - 1);

    typedef enum logic [1:0] {
        ST_ASSERTED,
        ST_HOLD,
        ST_RELEASED
    } state_t;

    logic [SYNC_STAGES-1:0][NUM_INPUTS-1:0] sync_q;
    logic [NUM_INPUTS-1:0]                  synced;

    logic [DB_W-1:0]       db_cnt_q   [NUM_INPUTS];
    logic [DB_W-1:0]       db_cnt_nxt [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] deb_q;
    logic [NUM_INPUTS-1:0] deb_nxt;
    logic [NUM_INPUTS-1:0] rise_q;
    logic [NUM_INPUTS-1:0] fall_q;

    state_t              state_q;
    state_t              state_nxt;
    logic [HOLD_W-1:0]   hold_q;
    logic [HOLD_W-1:0]   hold_nxt;
    logic                soc_rst_n_q;
    logic                btn;

    logic [DIV_W-1:0]    div_q;
    logic                ce_q;

    // Synchroniser stage: raw pins enter at index 0, the oldest sample is at the top.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], io.raw_inputs};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Debounce stage: a change is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
        deb_nxt = deb_q;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            db_cnt_nxt[i] = '0;
            if (synced[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    deb_nxt[i] = synced[i];
                end else begin
                    db_cnt_nxt[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                db_cnt_q[i] <= '0;
            end
            deb_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                db_cnt_q[i] <= db_cnt_nxt[i];
            end
            deb_q  <= deb_nxt;
            rise_q <= deb_nxt & ~deb_q;
            fall_q <= ~deb_nxt & deb_q;
        end
    end

    // Reset stretcher stage. The button is taken from the debouncer's next value so that
    // soc_reset_n reacts on the same edge the debounced level changes.
    assign btn = deb_nxt[RESET_INPUT_INDEX];

    always_comb begin
        state_nxt = state_q;
        hold_nxt  = hold_q;
        case (state_q)
            ST_ASSERTED: begin
                if (!btn) begin
                    state_nxt = ST_HOLD;
                    hold_nxt  = HOLD_INIT;
                end
            end
            ST_HOLD: begin
                hold_nxt = hold_q - HOLD_W'(1);
                if (btn) begin
                    state_nxt = ST_ASSERTED;
                end else if (hold_q <= HOLD_W'(1)) begin
                    state_nxt = ST_RELEASED;
                end
            end
            ST_RELEASED: begin
                if (btn) begin
                    state_nxt = ST_ASSERTED;
                end
            end
            default: begin
                state_nxt = ST_ASSERTED;
                hold_nxt  = HOLD_INIT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_ASSERTED;
            hold_q      <= HOLD_INIT;
            soc_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            hold_q      <= hold_nxt;
            soc_rst_n_q <= (state_nxt == ST_RELEASED);
        end
    end

    // Clock-enable stage: free-running modulo counter, strobe registered on the wrap edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            ce_q  <= 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
            ce_q  <= 1'b1;
        end else begin
            div_q <= div_q + DIV_W'(1);
            ce_q  <= 1'b0;
        end
    end

    assign io.debounced    = deb_q;
    assign io.rise_pulse   = rise_q;
    assign io.fall_pulse   = fall_q;
    assign io.soc_reset_n  = soc_rst_n_q;
    assign io.clock_enable = ce_q;

endmodule

// File: tb/tb_rvx_board_input_conditioner.sv
// Directed bench for rvx_board_input_conditioner: expectations are queued with their due
// cycle when stimulus is applied and checked by a monitor when that cycle arrives.
module tb_rvx_board_input_conditioner;

    localparam int N = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    rvx_board_input_conditioner_if #(.NUM_INPUTS(N)) bus  ();
    rvx_board_input_conditioner_if #(.NUM_INPUTS(N)) bus1 ();

    rvx_board_input_conditioner #(
        .NUM_INPUTS(N), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8),
        .RESET_INPUT_INDEX(0), .RESET_HOLD_CYCLES(16), .CLOCK_DIVIDER(3)
    ) dut (
        .clock(clock), .reset_n(reset_n), .io(bus)
    );

    rvx_board_input_conditioner #(
        .NUM_INPUTS(N), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8),
        .RESET_INPUT_INDEX(0), .RESET_HOLD_CYCLES(16), .CLOCK_DIVIDER(1)
    ) dut_div1 (
        .clock(clock), .reset_n(reset_n), .io(bus1)
    );

    localparam int SEL_SOC  = 0;
    localparam int SEL_DEB  = 1;
    localparam int SEL_RISE = 2;
    localparam int SEL_FALL = 3;

    typedef struct {
        string      tag;
        int         at;
        int         sel;
        logic [3:0] val;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc;
    int   rise_cnt [N];
    int   fall_cnt [N];

    // Edges since the last reset_n release; the first edge with reset_n high is cycle 1.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic void expect_at(string tag, int at, int sel, logic [3:0] val);
        exp_t e;
        e.tag = tag;
        e.at  = at;
        e.sel = sel;
        e.val = val;
        q.push_back(e);
    endfunction

    function automatic logic [3:0] observe(int sel);
        case (sel)
            SEL_SOC:  return {3'b000, bus.soc_reset_n};
            SEL_DEB:  return bus.debounced;
            SEL_RISE: return bus.rise_pulse;
            default:  return bus.fall_pulse;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic wait_until(int t);
        while (cyc < t) @(negedge clock);
    endtask

    always @(negedge clock) begin
        logic [3:0] obs;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].at <= cyc) begin
                checks++;
                obs = observe(q[i].sel);
                if (q[i].at < cyc) begin
                    errors++;
                    $error("FAIL %s: stale expectation due at cycle %0d, now %0d", q[i].tag, q[i].at, cyc);
                end else begin
                    assert (obs === q[i].val) else begin
                        errors++;
                        $error("FAIL %s: observed=%b expected=%b at cycle %0d", q[i].tag, obs, q[i].val, cyc);
                    end
                end
                q.delete(i);
            end
        end
        checks++;
        assert ((bus.rise_pulse & bus.fall_pulse) === 4'b0000) else begin
            errors++;
            $error("FAIL pulse_exclusive: rise=%b fall=%b required no overlap", bus.rise_pulse, bus.fall_pulse);
        end
        for (int i = 0; i < N; i++) begin
            if (bus.rise_pulse[i] === 1'b1) rise_cnt[i]++;
            if (bus.fall_pulse[i] === 1'b1) fall_cnt[i]++;
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c, r, f, g;
        for (int i = 0; i < N; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
        end
        bus.raw_inputs  = '0;
        bus1.raw_inputs = '0;
        reset_n = 1'b0;

        // Reset values while reset_n is held low.
        repeat (3) @(negedge clock);
        chk("rst_soc",  {31'd0, bus.soc_reset_n}, 0);
        chk("rst_deb",  {28'd0, bus.debounced}, 0);
        chk("rst_rise", {28'd0, bus.rise_pulse}, 0);
        chk("rst_fall", {28'd0, bus.fall_pulse}, 0);
        chk("rst_ce",   {31'd0, bus.clock_enable}, 0);
        chk("rst_ce1",  {31'd0, bus1.clock_enable}, 0);

        // Scenario 1: power-up stretch, soc_reset_n rises at edge 17.
        reset_n = 1'b1;
        expect_at("pwr_soc_low_e1",  1,  SEL_SOC, 4'd0);
        expect_at("pwr_soc_low_e16", 16, SEL_SOC, 4'd0);
        expect_at("pwr_soc_high_e17", 17, SEL_SOC, 4'd1);
        expect_at("pwr_soc_high_e25", 25, SEL_SOC, 4'd1);
        expect_at("pwr_deb_idle",    17, SEL_DEB, 4'b0000);

        // Scenario 5: clock_enable patterns for divider 3 and divider 1.
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            chk("ce_div3", {31'd0, bus.clock_enable}, (cyc % 3 == 0) ? 1 : 0);
            chk("ce_div1", {31'd0, bus1.clock_enable}, 1);
        end
        wait_until(30);
        chk("pwr_no_rise", rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3], 0);
        chk("pwr_no_fall", fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3], 0);

        // Scenario 2: clean press and release on channel 2.
        c = cyc;
        bus.raw_inputs[2] = 1'b1;
        expect_at("ch2_deb_before", c + 9,  SEL_DEB,  4'b0000);
        expect_at("ch2_deb_rise",   c + 10, SEL_DEB,  4'b0100);
        expect_at("ch2_rise_early", c + 9,  SEL_RISE, 4'b0000);
        expect_at("ch2_rise_pulse", c + 10, SEL_RISE, 4'b0100);
        expect_at("ch2_rise_gone",  c + 11, SEL_RISE, 4'b0000);
        repeat (20) @(negedge clock);
        c = cyc;
        bus.raw_inputs[2] = 1'b0;
        expect_at("ch2_deb_hold",   c + 9,  SEL_DEB,  4'b0100);
        expect_at("ch2_deb_fall",   c + 10, SEL_DEB,  4'b0000);
        expect_at("ch2_fall_early", c + 9,  SEL_FALL, 4'b0000);
        expect_at("ch2_fall_pulse", c + 10, SEL_FALL, 4'b0100);
        expect_at("ch2_fall_gone",  c + 11, SEL_FALL, 4'b0000);
        expect_at("ch2_no_rise",    c + 10, SEL_RISE, 4'b0000);
        repeat (15) @(negedge clock);
        chk("ch2_rise_count", rise_cnt[2], 1);
        chk("ch2_fall_count", fall_cnt[2], 1);

        // Scenario 3: glitches of 7 cycles on channel 1 are rejected.
        c = cyc;
        bus.raw_inputs[1] = 1'b1;
        expect_at("ch1_glitch_a", c + 9, SEL_DEB, 4'b0000);
        repeat (7) @(negedge clock);
        bus.raw_inputs[1] = 1'b0;
        repeat (1) @(negedge clock);
        bus.raw_inputs[1] = 1'b1;
        repeat (7) @(negedge clock);
        bus.raw_inputs[1] = 1'b0;
        c = cyc;
        expect_at("ch1_glitch_b", c + 3,  SEL_DEB, 4'b0000);
        expect_at("ch1_glitch_c", c + 10, SEL_DEB, 4'b0000);
        repeat (15) @(negedge clock);
        chk("ch1_rise_count", rise_cnt[1], 0);
        chk("ch1_fall_count", fall_cnt[1], 0);

        // Scenario 4: reset button press, release and hold timing.
        c = cyc;
        bus.raw_inputs[0] = 1'b1;
        expect_at("btn_soc_before", c + 9,  SEL_SOC, 4'd1);
        expect_at("btn_soc_assert", c + 10, SEL_SOC, 4'd0);
        expect_at("btn_deb_rise",   c + 10, SEL_DEB, 4'b0001);
        repeat (20) @(negedge clock);
        r = cyc;
        bus.raw_inputs[0] = 1'b0;
        f = r + 10;
        expect_at("btn_deb_fall",     f,      SEL_DEB, 4'b0000);
        expect_at("btn_hold_last",    f + 15, SEL_SOC, 4'd0);
        expect_at("btn_hold_release", f + 16, SEL_SOC, 4'd1);
        wait_until(f + 20);

        c = cyc;
        bus.raw_inputs[0] = 1'b1;
        expect_at("btn2_soc_assert", c + 10, SEL_SOC, 4'd0);
        repeat (20) @(negedge clock);
        r = cyc;
        bus.raw_inputs[0] = 1'b0;
        f = r + 10;
        expect_at("btn2_hold_start", f,     SEL_SOC, 4'd0);
        expect_at("btn2_hold_mid",   f + 5, SEL_SOC, 4'd0);
        wait_until(f + 2);
        bus.raw_inputs[0] = 1'b1;
        expect_at("repress_deb",        f + 12, SEL_DEB, 4'b0001);
        expect_at("repress_soc",        f + 12, SEL_SOC, 4'd0);
        expect_at("repress_no_release", f + 16, SEL_SOC, 4'd0);
        expect_at("repress_still_low",  f + 17, SEL_SOC, 4'd0);
        repeat (20) @(negedge clock);
        r = cyc;
        bus.raw_inputs[0] = 1'b0;
        g = r + 10;
        expect_at("rehold_last",    g + 15, SEL_SOC, 4'd0);
        expect_at("rehold_release", g + 16, SEL_SOC, 4'd1);
        wait_until(g + 20);

        // Scenario 6a: reset_n asserted mid-debounce.
        chk("queue_drained_a", q.size(), 0);
        bus.raw_inputs[2] = 1'b1;
        repeat (20) @(negedge clock);
        chk("pre_rst_deb", {28'd0, bus.debounced}, 32'h4);
        bus.raw_inputs[3] = 1'b1;
        repeat (6) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("mid_db_soc",  {31'd0, bus.soc_reset_n}, 0);
        chk("mid_db_deb",  {28'd0, bus.debounced}, 0);
        chk("mid_db_rise", {28'd0, bus.rise_pulse}, 0);
        chk("mid_db_fall", {28'd0, bus.fall_pulse}, 0);
        chk("mid_db_ce",   {31'd0, bus.clock_enable}, 0);
        bus.raw_inputs = '0;
        repeat (3) @(negedge clock);
        chk("mid_db_deb_held", {28'd0, bus.debounced}, 0);
        reset_n = 1'b1;
        expect_at("re1_soc_low",  16, SEL_SOC, 4'd0);
        expect_at("re1_soc_high", 17, SEL_SOC, 4'd1);
        expect_at("re1_deb",      17, SEL_DEB, 4'b0000);
        wait_until(20);
        c = cyc;
        bus.raw_inputs[3] = 1'b1;
        expect_at("re1_ch3_full_count", c + 9,  SEL_DEB, 4'b0000);
        expect_at("re1_ch3_rise",       c + 10, SEL_DEB, 4'b1000);
        repeat (15) @(negedge clock);

        // Scenario 6b: reset_n asserted mid-hold.
        bus.raw_inputs[0] = 1'b1;
        repeat (20) @(negedge clock);
        r = cyc;
        bus.raw_inputs[0] = 1'b0;
        f = r + 10;
        wait_until(f + 5);
        chk("mid_hold_soc_pre", {31'd0, bus.soc_reset_n}, 0);
        chk("queue_drained_b", q.size(), 0);
        reset_n = 1'b0;
        #1;
        chk("mid_hold_soc", {31'd0, bus.soc_reset_n}, 0);
        chk("mid_hold_deb", {28'd0, bus.debounced}, 0);
        chk("mid_hold_ce",  {31'd0, bus.clock_enable}, 0);
        bus.raw_inputs = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        expect_at("re2_soc_low",  16, SEL_SOC, 4'd0);
        expect_at("re2_soc_high", 17, SEL_SOC, 4'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("re2_ce_div3", {31'd0, bus.clock_enable}, (cyc % 3 == 0) ? 1 : 0);
        end
        wait_until(25);
        chk("queue_drained_end", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
